// File: rtl/capture_compare_channel.sv
// One capture/compare channel of the general-purpose timer. In compare mode it drives a
// match flag and a PWM/compare output. In capture mode it latches the counter on filtered input edges.
module capture_compare_channel #(
    parameter int CNT_WIDTH = 32,
    parameter int FLT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 dir_i,
    input  logic                 uev_i,
    input  logic                 cce_i,
    input  logic [1:0]           ccs_i,
    input  logic [2:0]           ocm_i,
    input  logic                 ocpe_i,
    input  logic                 ccp_i,
    input  logic [CNT_WIDTH-1:0] ccr_i,
    input  logic [FLT_WIDTH-1:0] icf_i,
    input  logic [1:0]           icpsc_i,
    input  logic                 ti_i,
    input  logic                 ccg_i,
    input  logic                 ccif_clr_i,
    input  logic                 ccof_clr_i,
    output logic [CNT_WIDTH-1:0] ccr_o,
    output logic                 ccif_o,
    output logic                 ccof_o,
    output logic                 oc_o
);

    typedef enum logic [1:0] {
        MODE_DIS = 2'd0,
        MODE_CMP = 2'd1,
        MODE_CAP = 2'd2
    } mode_e;

    mode_e mode_q, mode_d;

    logic                 ti_meta_q, ti_sync_q;
    logic                 tf_q, tf_d;
    logic [FLT_WIDTH-1:0] flt_cnt_q, flt_cnt_d, flt_cnt_inc;
    logic [2:0]           psc_q, psc_d, psc_mask;
    logic                 match_q, ocref_q, ocref_d;
    logic                 leaving_cap, tf_edge, qualified;
    logic                 match, match_evt, pwm1, act;
    logic                 cap_evt, cmp_evt, ccr_load;

    // Mode register: software selection is re-evaluated every cycle.
    always_comb begin
        mode_d = MODE_DIS;
        if (cce_i && ccs_i == 2'b00) begin
            mode_d = MODE_CMP;
        end else if (cce_i && ccs_i == 2'b01) begin
            mode_d = MODE_CAP;
        end
    end

    assign leaving_cap = (mode_q == MODE_CAP) && (mode_d != MODE_CAP);

    // Filtered level follows the synchronized input only after icf_i consecutive differing cycles.
    assign flt_cnt_inc = flt_cnt_q + 1'b1;

    always_comb begin
        tf_d      = tf_q;
        flt_cnt_d = '0;
        if (ti_sync_q != tf_q) begin
            if (flt_cnt_inc >= icf_i) begin
                tf_d = ti_sync_q;
            end else begin
                flt_cnt_d = flt_cnt_inc;
            end
        end
        if (leaving_cap) begin
            flt_cnt_d = '0;
        end
    end

    // Edge is flagged in the cycle the filtered level changes, so capture sees that cycle's counter.
    assign tf_edge = (tf_d != tf_q) && (tf_d != ccp_i);

    always_comb begin
        case (icpsc_i)
            2'b00:   psc_mask = 3'b000;
            2'b01:   psc_mask = 3'b001;
            2'b10:   psc_mask = 3'b011;
            default: psc_mask = 3'b111;
        endcase
    end

    assign qualified = tf_edge && ((psc_q & psc_mask) == psc_mask);

    always_comb begin
        psc_d = psc_q;
        if (leaving_cap) begin
            psc_d = '0;
        end else if (mode_q == MODE_CAP && tf_edge) begin
            psc_d = psc_q + 3'd1;
        end
    end

    assign match     = (cnt_i == ccr_o);
    assign match_evt = match && !match_q;
    assign pwm1      = dir_i ? (cnt_i <= ccr_o) : (cnt_i < ccr_o);
    assign act       = match_evt || ccg_i;

    always_comb begin
        ocref_d = ocref_q;
        if (mode_q != MODE_CMP) begin
            ocref_d = 1'b0;
        end else begin
            case (ocm_i)
                3'b001:  if (act) ocref_d = 1'b1;
                3'b010:  if (act) ocref_d = 1'b0;
                3'b011:  if (act) ocref_d = ~ocref_q;
                3'b100:  ocref_d = 1'b0;
                3'b101:  ocref_d = 1'b1;
                3'b110:  ocref_d = pwm1;
                3'b111:  ocref_d = ~pwm1;
                default: ocref_d = ocref_q;
            endcase
        end
    end

    assign cap_evt  = (mode_q == MODE_CAP) && (qualified || ccg_i);
    assign cmp_evt  = (mode_q == MODE_CMP) && act;
    assign ccr_load = (mode_q == MODE_CMP) && (!ocpe_i || uev_i);

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            mode_q    <= MODE_DIS;
            ti_meta_q <= 1'b0;
            ti_sync_q <= 1'b0;
            tf_q      <= 1'b0;
            flt_cnt_q <= '0;
            psc_q     <= '0;
            match_q   <= 1'b0;
            ocref_q   <= 1'b0;
            ccr_o     <= '0;
            ccif_o    <= 1'b0;
            ccof_o    <= 1'b0;
            oc_o      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            ti_meta_q <= ti_i;
            ti_sync_q <= ti_meta_q;
            tf_q      <= tf_d;
            flt_cnt_q <= flt_cnt_d;
            psc_q     <= psc_d;
            match_q   <= match;
            ocref_q   <= ocref_d;
            oc_o      <= (mode_q == MODE_CMP) ? (ocref_q ^ ccp_i) : 1'b0;

            if (cap_evt) begin
                ccr_o <= cnt_i;
            end else if (ccr_load) begin
                ccr_o <= ccr_i;
            end

            // A set in the same cycle as a clear wins.
            if (cap_evt || cmp_evt) begin
                ccif_o <= 1'b1;
            end else if (ccif_clr_i) begin
                ccif_o <= 1'b0;
            end

            if (cap_evt && ccif_o && !ccif_clr_i) begin
                ccof_o <= 1'b1;
            end else if (ccof_clr_i) begin
                ccof_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_capture_compare_channel.sv
// Directed bench for capture_compare_channel: compare/PWM, preload, toggle, capture,
// filter/prescaler, reset and flag priority, checked against a queue of expected results.
module tb_capture_compare_channel;

    logic        clk_i = 1'b0;
    logic        aresetn_i;
    logic [31:0] cnt_i;
    logic        dir_i, uev_i, cce_i;
    logic [1:0]  ccs_i;
    logic [2:0]  ocm_i;
    logic        ocpe_i, ccp_i;
    logic [31:0] ccr_i;
    logic [3:0]  icf_i;
    logic [1:0]  icpsc_i;
    logic        ti_i, ccg_i, ccif_clr_i, ccof_clr_i;
    logic [31:0] ccr_o;
    logic        ccif_o, ccof_o, oc_o;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          highs, toggles, caps;
    logic        prev_oc;
    logic [31:0] e32;
    bit          ok;

    capture_compare_channel #(.CNT_WIDTH(32), .FLT_WIDTH(4)) dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i), .cnt_i(cnt_i), .dir_i(dir_i), .uev_i(uev_i),
        .cce_i(cce_i), .ccs_i(ccs_i), .ocm_i(ocm_i), .ocpe_i(ocpe_i), .ccp_i(ccp_i),
        .ccr_i(ccr_i), .icf_i(icf_i), .icpsc_i(icpsc_i), .ti_i(ti_i), .ccg_i(ccg_i),
        .ccif_clr_i(ccif_clr_i), .ccof_clr_i(ccof_clr_i), .ccr_o(ccr_o), .ccif_o(ccif_o),
        .ccof_o(ccof_o), .oc_o(oc_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sweep a 0..9 counter; expected PWM1 level is queued when cnt_i is driven and
    // popped two cycles later when oc_o reflects it.
    task automatic oc_sweep(input logic [31:0] ccr_val, input logic down, input int periods,
                            output int n_high);
        logic e;
        int   c;
        n_high = 0;
        exp_q.delete();
        for (int p = 0; p < periods; p++) begin
            for (int k = 0; k < 10; k++) begin
                c     = down ? 9 - k : k;
                cnt_i = c;
                dir_i = down;
                uev_i = (k == 9);
                e     = down ? (cnt_i <= ccr_val) : (cnt_i < ccr_val);
                exp_q.push_back({31'b0, e});
                step();
                if (exp_q.size() >= 2) begin
                    e32 = exp_q.pop_front();
                    check_bit("oc_pwm", oc_o, e32[0]);
                    if (oc_o) n_high++;
                end
            end
        end
        uev_i = 1'b0;
        dir_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_flag(input bit use_ccof, input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if ((use_ccof ? ccof_o : ccif_o) === 1'b1) begin
                found = 1'b1;
                break;
            end
            cnt_i = cnt_i + 1;
        end
    endtask

    task automatic cap_obs_step();
        step();
        if (ccif_o) begin
            caps++;
            ccif_clr_i = 1'b1;
        end else begin
            ccif_clr_i = 1'b0;
        end
        cnt_i = cnt_i + 1;
    endtask

    initial begin
        aresetn_i = 1'b0; cnt_i = '0; dir_i = 1'b0; uev_i = 1'b0; cce_i = 1'b0;
        ccs_i = 2'b00; ocm_i = 3'b000; ocpe_i = 1'b0; ccp_i = 1'b0; ccr_i = '0;
        icf_i = '0; icpsc_i = 2'b00; ti_i = 1'b0; ccg_i = 1'b0;
        ccif_clr_i = 1'b0; ccof_clr_i = 1'b0;
        step(); step();
        check_val("rst_ccr", ccr_o, 32'd0);
        check_bit("rst_ccif", ccif_o, 1'b0);
        check_bit("rst_ccof", ccof_o, 1'b0);
        check_bit("rst_oc", oc_o, 1'b0);
        aresetn_i = 1'b1;

        // PWM1 with preload: load 3 via an update event, then check ccif at cnt 3
        cce_i = 1'b1; ccs_i = 2'b00; ocm_i = 3'b110; ocpe_i = 1'b1; ccr_i = 32'd3; cnt_i = 32'd9;
        step();
        uev_i = 1'b1; step(); uev_i = 1'b0;
        check_val("pwm_ccr_load", ccr_o, 32'd3);
        ccif_clr_i = 1'b1; step(); ccif_clr_i = 1'b0;
        check_bit("pwm_ccif_clr", ccif_o, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cnt_i = c;
            step();
            if (c == 2) check_bit("ccif_before_match", ccif_o, 1'b0);
            if (c == 3) check_bit("ccif_at_match", ccif_o, 1'b1);
        end
        oc_sweep(32'd3, 1'b0, 2, highs);
        check_val("pwm1_up_duty", highs, 6);

        // Preload: ccr_i changes mid-period, active value follows only at the update event
        for (int c = 0; c < 10; c++) begin
            cnt_i = c;
            if (c == 5) ccr_i = 32'd7;
            uev_i = (c == 9);
            step();
            check_val("preload_ccr", ccr_o, (c == 9) ? 32'd7 : 32'd3);
        end
        uev_i = 1'b0;
        ocpe_i = 1'b0; ccr_i = 32'd4;
        step();
        check_val("direct_ccr", ccr_o, 32'd4);

        // PWM boundaries and down counting
        ccr_i = 32'd0; step(); step();
        oc_sweep(32'd0, 1'b0, 2, highs);
        check_val("pwm_ccr0_inactive", highs, 0);
        ccr_i = 32'd20; step(); step();
        oc_sweep(32'd20, 1'b0, 2, highs);
        check_val("pwm_ccr_gt_arr_active", highs, 19);
        ccr_i = 32'd3; step(); step();
        oc_sweep(32'd3, 1'b1, 2, highs);
        check_val("pwm1_down_duty", highs, 7);

        // Forced levels and polarity
        ocm_i = 3'b101; ccp_i = 1'b1; step(); step(); step();
        check_bit("force1_inverted", oc_o, 1'b0);
        ccp_i = 1'b0; step();
        check_bit("force1_plain", oc_o, 1'b1);

        // Toggle on match: once per period, and once only while the counter sits at 5
        ocm_i = 3'b011; ccr_i = 32'd5; cnt_i = '0;
        step(); step(); step();
        prev_oc = oc_o;
        toggles = 0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 10; c++) begin
                cnt_i = c;
                step();
                if (oc_o != prev_oc) toggles++;
                prev_oc = oc_o;
            end
        end
        check_val("toggle_per_period", toggles, 2);
        toggles = 0;
        cnt_i = 32'd5;
        for (int k = 0; k < 12; k++) begin
            step();
            if (oc_o != prev_oc) toggles++;
            prev_oc = oc_o;
        end
        check_val("toggle_stopped_counter", toggles, 1);

        // Capture: rising edge while cnt_i=100 is latched two cycles later
        ccs_i = 2'b01; ccp_i = 1'b0; icf_i = '0; icpsc_i = 2'b00; ti_i = 1'b0; cnt_i = 32'd50;
        step(); step(); step(); step();
        check_bit("cmp_out_off_in_cap", oc_o, 1'b0);
        ccif_clr_i = 1'b1; ccof_clr_i = 1'b1; step(); ccif_clr_i = 1'b0; ccof_clr_i = 1'b0;
        check_bit("cap_ccif_clear", ccif_o, 1'b0);
        cnt_i = 32'd100; ti_i = 1'b1;
        exp_q.push_back(32'd102);
        wait_flag(1'b0, 10, ok);
        check_bit("cap1_seen", ok, 1'b1);
        check_val("cap1_value", ccr_o, exp_q.pop_front());
        check_bit("cap1_no_ccof", ccof_o, 1'b0);
        ti_i = 1'b0; cnt_i = 32'd150;
        step(); step(); step(); step();
        check_val("falling_ignored", ccr_o, 32'd102);
        cnt_i = 32'd200; ti_i = 1'b1;
        exp_q.push_back(32'd202);
        wait_flag(1'b1, 10, ok);
        check_bit("cap2_ccof_seen", ok, 1'b1);
        check_val("cap2_value", ccr_o, exp_q.pop_front());
        check_bit("cap2_ccif", ccif_o, 1'b1);

        // Filter: a 3-cycle glitch with N=4 must not capture
        ccif_clr_i = 1'b1; ccof_clr_i = 1'b1; step(); ccif_clr_i = 1'b0; ccof_clr_i = 1'b0;
        icf_i = 4'd4; ti_i = 1'b0;
        for (int k = 0; k < 10; k++) step();
        ti_i = 1'b1; step(); step(); step();
        ti_i = 1'b0;
        for (int k = 0; k < 12; k++) step();
        check_bit("glitch_filtered", ccif_o, 1'b0);

        // Prescaler every 2 edges: 4 clean rising edges give 2 captures
        icpsc_i = 2'b01; caps = 0;
        for (int e = 0; e < 4; e++) begin
            ti_i = 1'b1;
            for (int k = 0; k < 8; k++) cap_obs_step();
            ti_i = 1'b0;
            for (int k = 0; k < 8; k++) cap_obs_step();
        end
        ccif_clr_i = 1'b0;
        check_val("prescaler_captures", caps, 2);

        // Reset mid-PWM with oc_o high
        ccs_i = 2'b00; ocm_i = 3'b110; ocpe_i = 1'b0; ccr_i = 32'd8; icf_i = '0; icpsc_i = 2'b00;
        cnt_i = '0; dir_i = 1'b0;
        step(); step(); step(); step();
        check_bit("pre_reset_oc", oc_o, 1'b1);
        ccg_i = 1'b1; step(); ccg_i = 1'b0;
        check_bit("ccg_sets_ccif", ccif_o, 1'b1);
        aresetn_i = 1'b0; step(); aresetn_i = 1'b1;
        check_bit("mid_rst_oc", oc_o, 1'b0);
        check_val("mid_rst_ccr", ccr_o, 32'd0);
        check_bit("mid_rst_ccif", ccif_o, 1'b0);
        check_bit("mid_rst_ccof", ccof_o, 1'b0);

        // Software capture, then a capture coinciding with ccif_clr: set wins, no overcapture
        ccs_i = 2'b01; ti_i = 1'b0; cnt_i = 32'd300;
        step(); step(); step();
        ccg_i = 1'b1;
        exp_q.push_back(32'd300);
        step(); ccg_i = 1'b0;
        check_bit("ccg_cap_ccif", ccif_o, 1'b1);
        check_val("ccg_cap_value", ccr_o, exp_q.pop_front());
        cnt_i = 32'd400; ti_i = 1'b1;
        exp_q.push_back(32'd402);
        step(); cnt_i = 32'd401;
        step(); cnt_i = 32'd402; ccif_clr_i = 1'b1;
        step(); ccif_clr_i = 1'b0;
        check_bit("set_beats_clear", ccif_o, 1'b1);
        check_bit("clear_blocks_ccof", ccof_o, 1'b0);
        check_val("clr_cap_value", ccr_o, exp_q.pop_front());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
